// File: rtl/debug_step_ctrl.sv
// Debug-side step/run controller: decodes UART command bytes, drives the PC step
// enable, then returns the sampled PC to the UART transmitter LSB first.
module debug_step_ctrl #(
    parameter int NB      = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [NB_BYTE-1:0] i_cmd,
    input  logic [NB-1:0]      i_pc,
    input  logic               i_halt,
    input  logic               i_tx_ready,
    output logic               o_step,
    output logic               o_tx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic [NB-1:0]      o_step_count
);

    localparam int NBYTES = NB / NB_BYTE;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_STEP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;

    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'('h53);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'('h43);
    localparam logic [NB_BYTE-1:0] CMD_PC   = NB_BYTE'('h50);

    logic [2:0]                     state_q, state_d;
    logic                           step_q, step_d;
    logic                           tx_valid_q, tx_valid_d;
    logic [NB_BYTE-1:0]             tx_data_q, tx_data_d;
    logic                           busy_q, busy_d;
    logic [NB-1:0]                  step_count_q, step_count_d;
    logic [NBYTES-1:0][NB_BYTE-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               idx_nxt;

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        step_d     = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd)
                        CMD_STEP: begin
                            state_d = S_STEP;
                            step_d  = 1'b1;
                        end
                        CMD_CONT: begin
                            state_d = S_RUN;
                            step_d  = ~i_halt;
                        end
                        CMD_PC:  state_d = S_WAIT;
                        default: ;
                    endcase
                end
            end
            S_STEP: state_d = S_WAIT;
            // Outputs are registered, so each RUN cycle decides the next cycle's step.
            S_RUN: begin
                if (i_halt) state_d = S_WAIT;
                else        step_d  = 1'b1;
            end
            S_WAIT: begin
                shadow_d   = i_pc;
                idx_d      = '0;
                tx_valid_d = 1'b1;
                tx_data_d  = i_pc[NB_BYTE-1:0];
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        idx_d     = idx_nxt;
                        tx_data_d = shadow_q[idx_nxt];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        step_count_d = step_count_q + NB'(step_d);
        busy_d       = (state_d != S_IDLE);
    end

    // NOTE: state uses non-blocking assignments; the synchronous reset clears
    // every flop, including the PC shadow, so an abort leaves nothing pending.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            step_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            step_count_q <= '0;
            shadow_q     <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            step_count_q <= step_count_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
        end
    end

    assign o_step       = step_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_tx_data    = tx_data_q;
    assign o_busy       = busy_q;
    assign o_step_count = step_count_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: a transaction-level plan builds per-cycle stimulus and
// expected outputs up front; one process drives the plan and compares every cycle.
module tb_debug_step_ctrl;

    localparam int MAXC = 4096;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_valid;
    logic [7:0]  i_cmd;
    logic [31:0] i_pc;
    logic        i_halt;
    logic        i_tx_ready;
    logic        o_step;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic [31:0] o_step_count;

    debug_step_ctrl #(.NB(32), .NB_BYTE(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .i_pc        (i_pc),
        .i_halt      (i_halt),
        .i_tx_ready  (i_tx_ready),
        .o_step      (o_step),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_step_count(o_step_count)
    );

    always #5 i_clk = ~i_clk;

    // Per-cycle stimulus plan and expected outputs.
    bit          d_rst [MAXC];
    bit          d_cv  [MAXC];
    logic [7:0]  d_cmd [MAXC];
    bit          d_halt[MAXC];
    bit          d_rdy [MAXC];
    logic [31:0] d_pc  [MAXC];
    bit          e_chk [MAXC];
    bit          e_step[MAXC];
    bit          e_busy[MAXC];
    bit          e_txv [MAXC];
    logic [7:0]  e_txd [MAXC];
    logic [31:0] e_cnt [MAXC];

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } pin_t;
    pin_t pins[$];

    int          cur;
    logic [31:0] pc_cur;
    logic [31:0] cnt_cur;
    int          checks   = 0;
    int          failures = 0;

    function automatic bit rbit();
        return bit'($urandom & 1);
    endfunction

    function automatic logic [7:0] bad_cmd();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h53 || b == 8'h43 || b == 8'h50) b = 8'h41;
        return b;
    endfunction

    function automatic logic [7:0] any_cmd();
        case ($urandom % 4)
            0:       return 8'h53;
            1:       return 8'h43;
            2:       return 8'h50;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic bit nz_cv(input bit force_s);
        return force_s ? 1'b1 : ($urandom % 3 == 0);
    endfunction

    function automatic logic [7:0] nz_cmd(input bit force_s);
        return force_s ? 8'h53 : any_cmd();
    endfunction

    // One planned cycle: record inputs, expected outputs, and the pipeline PC advance.
    task automatic emit(input bit step, input bit busy, input bit txv, input logic [7:0] txd,
                        input bit halt, input bit rdy, input bit cv, input logic [7:0] cmd);
        d_rst[cur]  = 1'b0;
        d_cv[cur]   = cv;
        d_cmd[cur]  = cmd;
        d_halt[cur] = halt;
        d_rdy[cur]  = rdy;
        d_pc[cur]   = pc_cur;
        if (step) cnt_cur = cnt_cur + 32'd1;
        e_chk[cur]  = 1'b1;
        e_step[cur] = step;
        e_busy[cur] = busy;
        e_txv[cur]  = txv;
        e_txd[cur]  = txv ? txd : 8'h00;
        e_cnt[cur]  = cnt_cur;
        if (step) pc_cur = pc_cur + 32'd4;
        cur++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            emit(1'b0, 1'b0, 1'b0, 8'h00, rbit(), rbit(), rbit(), bad_cmd());
    endtask

    task automatic reset_cycle();
        idle(1);
        d_rst[cur-1] = 1'b1;
        cnt_cur = 32'd0;
    endtask

    task automatic pin(input int cyc, input int sig, input logic [31:0] val);
        pins.push_back('{cyc, sig, val});
    endtask

    // kind: 0 'S', 1 'C' (halt rises k cycles after the command), 2 'P', 3 invalid byte.
    // mode: 0 random ready, 1 ready always, 2 ready low for 3 cycles on byte 1.
    task automatic txn(input int kind, input int k, input int mode, input int abort_off,
                       input bit force_s, input logic [7:0] bad);
        int          t0;
        int          nb;
        int          stall;
        int          runs;
        int          a;
        bit          r;
        logic [31:0] sh;
        logic [7:0]  cmd;
        t0 = cur;
        case (kind)
            0:       cmd = 8'h53;
            1:       cmd = 8'h43;
            2:       cmd = 8'h50;
            default: cmd = bad;
        endcase
        emit(1'b0, 1'b0, 1'b0, 8'h00, (kind == 1) ? (k == 0) : rbit(), rbit(), 1'b1, cmd);
        if (kind == 3) return;
        if (kind == 0)
            emit(1'b1, 1'b1, 1'b0, 8'h00, rbit(), rbit(), nz_cv(force_s), nz_cmd(force_s));
        if (kind == 1) begin
            runs = (k == 0) ? 1 : k;
            for (int j = 1; j <= runs; j++)
                emit(k > 0, 1'b1, 1'b0, 8'h00, j >= k, rbit(), nz_cv(force_s), nz_cmd(force_s));
        end
        emit(1'b0, 1'b1, 1'b0, 8'h00, (kind == 1) ? 1'b1 : rbit(), rbit(),
             nz_cv(force_s), nz_cmd(force_s));
        sh    = d_pc[cur-1];
        nb    = 0;
        stall = 0;
        while (nb < 4) begin
            if (mode == 1) r = 1'b1;
            else if (mode == 2) begin
                if (nb == 1 && stall < 3) begin
                    r = 1'b0;
                    stall++;
                end else r = 1'b1;
            end else r = ($urandom % 4 != 0);
            emit(1'b0, 1'b1, 1'b1, sh[8*nb +: 8], (kind == 1) ? 1'b1 : rbit(), r,
                 nz_cv(force_s), nz_cmd(force_s));
            if (r) nb++;
        end
        if (abort_off >= 0 && t0 + abort_off < cur) begin
            a        = t0 + abort_off;
            d_rst[a] = 1'b1;
            cnt_cur  = 32'd0;
            pc_cur   = d_pc[a] + (e_step[a] ? 32'd4 : 32'd0);
            cur      = a + 1;
        end
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_sig(input int sig);
        case (sig)
            0:       return 32'(o_step);
            1:       return 32'(o_busy);
            2:       return 32'(o_tx_valid);
            3:       return 32'(o_tx_data);
            default: return o_step_count;
        endcase
    endfunction

    int t;
    int ncyc;
    int kind;

    initial begin
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = 8'h00; i_pc = 32'h0;
        i_halt = 1'b0;  i_tx_ready = 1'b0;

        cur = 0; pc_cur = 32'h4; cnt_cur = 32'd0;
        reset_cycle();
        e_chk[0] = 1'b0;
        reset_cycle();
        idle(2);

        // 'P' with PC 4: no step, bytes 04,00,00,00 from T+2.
        t = cur; txn(2, 0, 1, -1, 1'b0, 8'h00);
        pin(t+1, 0, 0); pin(t+2, 3, 32'h04); pin(t+2, 2, 1); pin(t+5, 2, 1);
        pin(t+5, 3, 32'h00); pin(t+6, 1, 0); pin(t+6, 2, 0);
        idle(1);

        // 'S': step only in T+1, PC 4->8 sent from T+3.
        t = cur; txn(0, 0, 1, -1, 1'b0, 8'h00);
        pin(t+1, 0, 1); pin(t+2, 0, 0); pin(t+3, 3, 32'h08); pin(t+3, 4, 1); pin(t+4, 3, 0);
        reset_cycle();
        idle(1);

        // 'C' with halt rising after 5 run cycles: 5 steps, PC 8+20 = 0x1C.
        t = cur; txn(1, 5, 1, -1, 1'b0, 8'h00);
        pin(t+1, 0, 1); pin(t+5, 0, 1); pin(t+6, 0, 0); pin(t+5, 4, 5);
        pin(t+7, 2, 1); pin(t+7, 3, 32'h1C);
        idle(1);

        // Back-pressure on byte 1 of 0xDEADBEEF with 'S' arriving throughout.
        pc_cur = 32'hDEADBEEF;
        idle(1);
        t = cur; txn(2, 0, 2, -1, 1'b1, 8'h00);
        pin(t+2, 3, 32'hEF); pin(t+3, 3, 32'hBE); pin(t+5, 3, 32'hBE); pin(t+6, 3, 32'hBE);
        pin(t+7, 3, 32'hAD); pin(t+8, 3, 32'hDE); pin(t+9, 1, 0); pin(t+4, 0, 0);

        // Reset in RUN after 3 steps, then reset during byte 2, then a clean 'P'.
        t = cur; txn(1, 8, 1, 3, 1'b0, 8'h00);
        pin(t+3, 4, 8); pin(t+4, 0, 0); pin(t+4, 4, 0); pin(t+4, 1, 0);
        t = cur; txn(2, 0, 1, 4, 1'b0, 8'h00);
        pin(t+4, 3, 32'hAD); pin(t+5, 2, 0); pin(t+5, 1, 0); pin(t+5, 3, 0);
        t = cur; txn(2, 0, 1, -1, 1'b0, 8'h00);
        pin(t+2, 3, 32'hFB); pin(t+3, 3, 32'hBE); pin(t+5, 3, 32'hDE);

        // Invalid byte in IDLE.
        t = cur; txn(3, 0, 1, -1, 1'b0, 8'h41);
        pin(t+1, 1, 0); pin(t+1, 0, 0);
        idle(1);

        for (int i = 0; i < 70; i++) begin
            if (cur > MAXC - 80) break;
            idle(int'($urandom_range(0, 3)));
            kind = int'($urandom % 4);
            if (kind == 2 && rbit()) pc_cur = $urandom;
            txn(kind, int'($urandom_range(0, 8)), (rbit() && rbit()) ? 1 : 0,
                ($urandom % 8 == 0) ? int'($urandom_range(0, 10)) : -1, 1'b0, bad_cmd());
        end
        idle(3);
        ncyc = cur;

        for (int c = 0; c < ncyc; c++) begin
            @(posedge i_clk);
            #1;
            i_reset     = d_rst[c];
            i_cmd_valid = d_cv[c];
            i_cmd       = d_cmd[c];
            i_halt      = d_halt[c];
            i_tx_ready  = d_rdy[c];
            i_pc        = d_pc[c];
            @(negedge i_clk);
            if (e_chk[c]) begin
                check("step",       c, 32'(o_step),     32'(e_step[c]));
                check("busy",       c, 32'(o_busy),     32'(e_busy[c]));
                check("tx_valid",   c, 32'(o_tx_valid), 32'(e_txv[c]));
                check("tx_data",    c, 32'(o_tx_data),  32'(e_txd[c]));
                check("step_count", c, o_step_count,    e_cnt[c]);
            end
            foreach (pins[i])
                if (pins[i].cyc == c)
                    check($sformatf("pin%0d", pins[i].sig), c, dut_sig(pins[i].sig), pins[i].val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
